uart_string_rx: RTL
===================

# uart_string_rx

Serial front end of the POV display: receives 8N1 UART bytes from the phone's Bluetooth link, packs printable characters into a fixed-width 7-bit-per-character string, and publishes it with a one-cycle `new_string` strobe. It is the producer side of the `string`/`new_string` interface that the LED top level consumes. The published string is held stable between commits.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency in Hz.
- `BAUD`, 9600, line rate. `CLKS_PER_BIT = CLK_HZ/BAUD` (integer division). Must be ≥ 4.
- `NCHARS`, 11, characters per string. Range 1..15.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous UART line; idles high.
- `string`  out  7*NCHARS  published string. Character 0 (first received) is in bits [7*NCHARS-1 : 7*NCHARS-7]; character k is 7 bits lower per step.
- `new_string`  out  1  one-cycle pulse on every commit.
- `frame_err`  out  1  one-cycle pulse when a stop bit samples low.
- `rx_busy`  out  1  high while the receiver FSM is not in IDLE.
- `char_count`  out  4  number of characters held in the assembly buffer.

## Operation
- `rx` passes through a 2-FF synchronizer. All FSM references below use the synchronized value `rxs`.
- Receiver FSM:
  - IDLE: `rxs` == 0 → START. The bit counter loads `CLKS_PER_BIT/2 - 1`.
  - START: at counter expiry, sample `rxs`. If 0 → DATA. If 1 → IDLE (false start; no pulse).
  - DATA: 8 samples spaced `CLKS_PER_BIT`, LSB first, shifted into the byte register → STOP.
  - STOP: after `CLKS_PER_BIT`, sample. If 1, assert internal `byte_valid` for one cycle. If 0, pulse `frame_err` and discard the byte. → IDLE in both cases.
- Packer acts on `byte_valid`:
  - 0x20..0x7E: write the low 7 bits into slot `char_count`, then increment. If the new count == NCHARS, commit.
  - 0x0D or 0x0A: commit if `char_count` > 0, otherwise ignore. This means CR LF produces exactly one commit.
  - Any other value (controls, ≥ 0x80): ignored.
- Commit:
  - `string` ← buffer, with unwritten slots padded to 0x20.
  - `new_string` = 1 for one cycle.
  - Buffer refilled with 0x20 and `char_count` ← 0.
- Reset values: `string` = all slots 0x20; `new_string`, `frame_err`, `rx_busy` = 0; `char_count` = 0; FSM in IDLE; buffer = 0x20.
- Reset mid-frame aborts the frame with no pulses. The partial buffer is discarded.

## Timing
- Let E be the first clock at which `rxs` == 0 in IDLE.
  - Start sample at E + CLKS_PER_BIT/2.
  - Data bit i sampled at E + CLKS_PER_BIT/2 + (i+1)·CLKS_PER_BIT.
  - Stop sampled at S = E + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT.
- `byte_valid` / `frame_err` are high in cycle S+1. `char_count`, `string` and `new_string` update in cycle S+2.
- `rx_busy` rises at E+1 and falls at S+1. The FSM re-arms at the mid stop bit, so back-to-back frames with one stop bit are received without loss.
- `new_string` is never high in two consecutive cycles. `string` changes only in the cycle `new_string` is high.
- `rx` input latency through the synchronizer is 2 cycles, counted before E.

## Test plan
Bench parameters: CLK_HZ=1_000_000, BAUD=100_000 (10 clk/bit), NCHARS=11.

- Reset, then idle `rx` high for 200 cycles → `string` = 11×0x20, no strobes, `rx_busy` = 0, `char_count` = 0.
- Send "HOLA" then 0x0D, back-to-back → exactly one `new_string`. `string` = 'H','O','L','A' followed by 7×0x20. `char_count` returns to 0.
- Send "HELLO WORLD!" (12 chars) with no terminator → commit after 'D' with `string` = "HELLO WORLD". '!' remains in the buffer with `char_count` = 1.
- Send 0x0D 0x0A with an empty buffer, then 0x41 0x0D 0x0A → exactly one commit, `string` = 'A' followed by 10×0x20.
- Frame 0x55 with the stop bit forced low → `frame_err` pulses once at S+1, `char_count` unchanged, no commit. Then a 0.3-bit low glitch on idle `rx` → no activity (false start).
- Assert `rst` during data bit 4 of a frame following "AB" → all outputs return to reset values. The next valid "Z" 0x0D yields 'Z' followed by 10×0x20.

Source files
------------

// File: rtl/uart_string_rx.sv
// 8N1 UART receiver that packs printable characters into a fixed-width 7-bit-per-char string.
// The published string is on port `str` because `string` is a reserved word in SystemVerilog.
module uart_string_rx #(
   parameter int CLK_HZ = 50_000_000,
   parameter int BAUD   = 9600,
   parameter int NCHARS = 11
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx,
   output logic [7*NCHARS-1:0]   str,
   output logic                  new_string,
   output logic                  frame_err,
   output logic                  rx_busy,
   output logic [3:0]            char_count
);

   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [6:0] SPACE = 7'h20;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic             rx_meta;
   logic             rxs;
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shreg;
   logic             byte_valid;

   logic [6:0]       char_buf  [NCHARS];
   logic [6:0]       next_buf  [NCHARS];
   logic [3:0]       next_count;
   logic             printable;
   logic             eol;
   logic             commit;

   // Synchronizer presets to the idle level so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments make both flops sample the pre-edge values,
      // giving two real register stages instead of a single wire-through.
      if (rst) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rx;
         rxs     <= rx_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         rx_busy    <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (!rxs) begin
                  state   <= START;
                  cnt     <= HALF_LOAD;
                  rx_busy <= 1'b1;
               end
            end
            START: begin
               if (cnt == '0) begin
                  if (!rxs) begin
                     state   <= DATA;
                     cnt     <= FULL_LOAD;
                     bit_idx <= '0;
                  end else begin
                     state   <= IDLE;
                     rx_busy <= 1'b0;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DATA: begin
               if (cnt == '0) begin
                  shreg <= {rxs, shreg[7:1]};
                  cnt   <= FULL_LOAD;
                  if (bit_idx == 3'd7) state <= STOP;
                  else                 bit_idx <= bit_idx + 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            STOP: begin
               // Re-arm at mid stop bit so a following start edge is not missed.
               if (cnt == '0) begin
                  if (rxs) byte_valid <= 1'b1;
                  else     frame_err  <= 1'b1;
                  state   <= IDLE;
                  rx_busy <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // shreg is stable while byte_valid is high: the next frame needs eight samples to touch it.
   always_comb begin
      // NOTE: every variable gets a default before any condition, so no path can infer a latch.
      next_buf   = char_buf;
      printable  = byte_valid && (shreg >= 8'h20) && (shreg <= 8'h7E);
      eol        = byte_valid && ((shreg == 8'h0D) || (shreg == 8'h0A));
      for (int i = 0; i < NCHARS; i++) begin
         if (printable && (char_count == 4'(i))) next_buf[i] = shreg[6:0];
      end
      next_count = char_count + {3'b000, printable};
      commit     = (printable && (next_count == 4'(NCHARS))) || (eol && (char_count != 4'd0));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the character buffer is a handful of flops, so it is reset explicitly;
         // a commit must never expose stale characters in unwritten slots.
         for (int i = 0; i < NCHARS; i++) char_buf[i] <= SPACE;
         char_count <= 4'd0;
         str        <= {NCHARS{SPACE}};
         new_string <= 1'b0;
      end else begin
         new_string <= commit;
         if (commit) begin
            for (int i = 0; i < NCHARS; i++) begin
               str[7*(NCHARS-i)-1 -: 7] <= next_buf[i];
               char_buf[i]              <= SPACE;
            end
            char_count <= 4'd0;
         end else begin
            for (int i = 0; i < NCHARS; i++) char_buf[i] <= next_buf[i];
            char_count <= next_count;
         end
      end
   end

endmodule
